// File: rtl/module_pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   stage_ctl_t            : control record that travels with each transaction
//   ovf_flag()             : signed two's-complement overflow from MSBs
//   geometry_ok()          : legality of a WIDTH/STAGES combination
package pkg_adder;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic valid;
    logic sub;
  } stage_ctl_t;

  // Overflow when both effective operands share a sign and the result's sign differs.
  function automatic logic ovf_flag(input logic a_msb, input logic b_eff_msb, input logic y_msb);
    return (a_msb == b_eff_msb) && (y_msb != a_msb);
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/module_pipelined_adder_slice.sv
// Registered C-bit slice adder.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   en_i           : pipeline advance enable (registers hold when low)
//   a_i, b_i       : slice operands (b_i already inverted for subtract)
//   cin_i          : carry into this slice
//   sum_d_o        : combinational slice sum (next value of sum_o)
//   sum_o, cout_o  : registered slice sum and carry out
module module_adder_slice #(
  parameter int C = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [C-1:0] a_i,
  input  logic [C-1:0] b_i,
  input  logic         cin_i,
  output logic [C-1:0] sum_d_o,
  output logic [C-1:0] sum_o,
  output logic         cout_o
);

  logic [C:0]   w_full;
  logic [C-1:0] r_sum;
  logic         r_cout;

  assign w_full  = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, cin_i};
  assign sum_d_o = w_full[C-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (en_i) begin
      r_sum  <= w_full[C-1:0];
      r_cout <= w_full[C];
    end
  end

  assign sum_o  = r_sum;
  assign cout_o = r_cout;

endmodule

// File: rtl/module_pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready handshakes.
// Stage k adds slice k (C = WIDTH/STAGES bits) using the carry registered by
// stage k-1. Unconsumed operand slices ride along in skew registers, finished
// result slices ride along in deskew registers, so a whole result leaves the
// last stage at once, STAGES cycles after it was accepted.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   valid_i, ready_o : input handshake (ready_o = ready_i | ~valid_o)
//   a_i, b_i         : operands
//   sub_i            : 1 = A-B, 0 = A+B+cin_i
//   cin_i            : carry-in for add mode
//   valid_o, ready_i : output handshake
//   y_o              : result mod 2^WIDTH
//   cout_o           : carry out of MSB (subtract: 1 = no borrow)
//   ovf_o            : signed overflow
//   zero_o           : y_o == 0
module module_pipelined_adder
  import pkg_adder::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int C = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("module_pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic w_en;
  logic w_valid_last;

  // The whole pipeline moves as one; a stalled full output freezes everything.
  assign w_en    = ready_i | ~w_valid_last;
  assign ready_o = w_en;
  assign valid_o = w_valid_last;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * C;  // operand bits not yet consumed at stage k

    logic [IW-1:0] w_a;
    logic [IW-1:0] w_b;
    logic          w_vld;
    logic          w_sub;
    logic          w_cin;
    logic          w_zlo_in;
    logic [C-1:0]  w_b_eff;
    logic [C-1:0]  w_sum_d;
    logic [C-1:0]  w_sum;
    logic          w_cout;
    logic          r_zlo;  // result slices 0..k of this transaction are all zero

    if (k == 0) begin : g_head
      assign w_a      = a_i;
      assign w_b      = b_i;
      assign w_vld    = valid_i;
      assign w_sub    = sub_i;
      assign w_cin    = sub_i | cin_i;  // subtract forces the +1 of two's complement
      assign w_zlo_in = 1'b1;
    end else begin : g_body
      assign w_a      = g_stage[k-1].g_skew.r_a;
      assign w_b      = g_stage[k-1].g_skew.r_b;
      assign w_vld    = g_stage[k-1].g_skew.r_ctl.valid;
      assign w_sub    = g_stage[k-1].g_skew.r_ctl.sub;
      assign w_cin    = g_stage[k-1].w_cout;
      assign w_zlo_in = g_stage[k-1].r_zlo;
    end

    // Raw B travels down the pipe; each stage inverts its own slice using the
    // transaction's sub bit.
    assign w_b_eff = w_b[C-1:0] ^ {C{w_sub}};

    // ---- stage k register boundary ----
    module_adder_slice #(.C(C)) u_slice (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (w_en),
      .a_i     (w_a[C-1:0]),
      .b_i     (w_b_eff),
      .cin_i   (w_cin),
      .sum_d_o (w_sum_d),
      .sum_o   (w_sum),
      .cout_o  (w_cout)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_zlo <= 1'b0;
      else if (w_en) r_zlo <= w_zlo_in & ~|w_sum_d;
    end

    if (k < STAGES - 1) begin : g_skew
      stage_ctl_t      r_ctl;
      logic [IW-C-1:0] r_a;
      logic [IW-C-1:0] r_b;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_ctl <= '0;
          r_a   <= '0;
          r_b   <= '0;
        end else if (w_en) begin
          r_ctl.valid <= w_vld;
          r_ctl.sub   <= w_sub;
          r_a         <= w_a[IW-1:C];
          r_b         <= w_b[IW-1:C];
        end
      end
    end else begin : g_tail
      logic r_vld;
      logic r_ovf;

      // The top slice holds the operand MSBs, so overflow is resolved here.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_vld <= 1'b0;
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_vld <= w_vld;
          r_ovf <= ovf_flag(w_a[C-1], w_b_eff[C-1], w_sum_d[C-1]);
        end
      end
    end

    if (k > 0) begin : g_lo
      logic [k*C-1:0] r_lo;
      logic [k*C-1:0] w_lo_d;

      if (k == 1) begin : g_first
        assign w_lo_d = g_stage[0].w_sum;
      end else begin : g_rest
        assign w_lo_d = {g_stage[k-1].w_sum, g_stage[k-1].g_lo.r_lo};
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_lo <= '0;
        else if (w_en) r_lo <= w_lo_d;
      end
    end
  end

  assign w_valid_last = g_stage[STAGES-1].g_tail.r_vld;
  assign ovf_o        = g_stage[STAGES-1].g_tail.r_ovf;
  assign cout_o       = g_stage[STAGES-1].w_cout;
  assign zero_o       = g_stage[STAGES-1].r_zlo;

  if (STAGES == 1) begin : g_y_single
    assign y_o = g_stage[0].w_sum;
  end else begin : g_y_multi
    assign y_o = {g_stage[STAGES-1].w_sum, g_stage[STAGES-1].g_lo.r_lo};
  end

endmodule

// File: tb/tb_module_pipelined_adder.sv
module tb_module_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [31:0] y;
    bit          cout;
    bit          ovf;
    bit          zero;
    int          t_in;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, sub, cin, valid_o, ready_i, cout_o, ovf_o, zero_o;
  logic [31:0] a, b, y_o;

  logic        s_valid, s_sub, s_cin;
  logic [7:0]  s_a, s_b;
  logic        s_rdy [3];
  logic        s_vo  [3];
  logic [7:0]  s_y   [3];
  logic        s_co  [3];
  logic        s_ov  [3];
  logic        s_z   [3];
  int          sw_st [3] = '{1, 2, 8};

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   lat_strict = 1'b1;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  module_pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a), .b_i(b), .sub_i(sub), .cin_i(cin),
    .valid_o(valid_o), .ready_i(ready_i), .y_o(y_o),
    .cout_o(cout_o), .ovf_o(ovf_o), .zero_o(zero_o)
  );

  module_pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(s_valid), .ready_o(s_rdy[0]),
    .a_i(s_a), .b_i(s_b), .sub_i(s_sub), .cin_i(s_cin),
    .valid_o(s_vo[0]), .ready_i(1'b1), .y_o(s_y[0]),
    .cout_o(s_co[0]), .ovf_o(s_ov[0]), .zero_o(s_z[0])
  );

  module_pipelined_adder #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(s_valid), .ready_o(s_rdy[1]),
    .a_i(s_a), .b_i(s_b), .sub_i(s_sub), .cin_i(s_cin),
    .valid_o(s_vo[1]), .ready_i(1'b1), .y_o(s_y[1]),
    .cout_o(s_co[1]), .ovf_o(s_ov[1]), .zero_o(s_z[1])
  );

  module_pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(s_valid), .ready_o(s_rdy[2]),
    .a_i(s_a), .b_i(s_b), .sub_i(s_sub), .cin_i(s_cin),
    .valid_o(s_vo[2]), .ready_i(1'b1), .y_o(s_y[2]),
    .cout_o(s_co[2]), .ovf_o(s_ov[2]), .zero_o(s_z[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                 input bit ts, input bit tc);
    exp_t   e;
    longint mask, lim, ua, ub, sa, sb, u, r;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    ua   = longint'(ta) & mask;
    ub   = longint'(tb) & mask;
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    if (ts) begin
      u      = ua - ub;
      r      = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      u      = ua + ub + longint'(tc);
      r      = sa + sb + longint'(tc);
      e.cout = (u > mask);
    end
    e.y    = 32'(u & mask);
    e.ovf  = (r >= lim) || (r < -lim);
    e.zero = ((u & mask) == 0);
    e.t_in = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: transfers are decided at the next rising edge, so look at the
  // handshake on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (valid_o && ready_i) begin
        chk("outq_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("y", y_o, e.y);
          chk("cout", cout_o, e.cout);
          chk("ovf", ovf_o, e.ovf);
          chk("zero", zero_o, e.zero);
          if (lat_strict) chk("latency", cyc + 1 - e.t_in, S);
        end
      end
      if (valid_i && ready_o) begin
        e      = model(W, a, b, sub, cin);
        e.t_in = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    tick(n);
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input bit ts, input bit tc);
    bit acc;
    int guard;
    guard = 0;
    a = ta; b = tb; sub = ts; cin = tc; valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    valid_i = 1'b0;
    while (q.size() != 0 && guard < 40) begin
      tick(1);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic sweep(input logic [7:0] ta, input logic [7:0] tb, input bit ts, input bit tc);
    exp_t e;
    bit   seen [3];
    e = model(8, {24'd0, ta}, {24'd0, tb}, ts, tc);
    for (int i = 0; i < 3; i++) seen[i] = 1'b0;
    s_a = ta; s_b = tb; s_sub = ts; s_cin = tc; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) chk("sw_ready", s_rdy[i], 1);
    tick(1);
    s_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && s_vo[i]) begin
          seen[i] = 1'b1;
          chk("sw_latency", n, sw_st[i]);
          chk("sw_y", s_y[i], e.y[7:0]);
          chk("sw_cout", s_co[i], e.cout);
          chk("sw_ovf", s_ov[i], e.ovf);
          chk("sw_zero", s_z[i], e.zero);
        end
      end
      tick(1);
    end
    for (int i = 0; i < 3; i++) chk("sw_seen", seen[i], 1);
  endtask

  initial begin : timeout
    #300000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] held;
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_valid", valid_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_cout", cout_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_zero", zero_o, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", ready_o, 1);

    // Directed cases with exact latency.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(6);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    idle(6);
    send(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    idle(6);

    // Random mixed add/sub stream with occasional bubbles.
    for (int i = 0; i < 24; i++) begin
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    // Backpressure: 8 transactions with ready_i low for 3 cycles mid-stream.
    lat_strict = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        valid_i = 1'b0;
      end
      begin
        tick(6);
        ready_i = 1'b0;
        held = y_o;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", ready_o, 0);
          chk("stall_valid", valid_o, 1);
          chk("stall_y_held", y_o, held);
          @(posedge clk);
        end
        #1 ready_i = 1'b1;
      end
    join
    drain();
    lat_strict = 1'b1;

    // Reset mid-stream: one result waiting at the output, three in flight.
    for (int i = 0; i < 4; i++) send($urandom | 32'h1, $urandom, 1'b0, 1'b0);
    valid_i = 1'b0;
    chk("pre_rst_valid", valid_o, 1);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_y", y_o, 0);
    chk("async_rst_cout", cout_o, 0);
    chk("async_rst_ovf", ovf_o, 0);
    chk("async_rst_zero", zero_o, 0);
    tick(2);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_valid", valid_o, 0);
    end
    tick(1);

    // Narrow instances: depth 1, 2 and 8.
    sweep(8'hFF, 8'h01, 1'b0, 1'b0);
    sweep(8'h80, 8'h01, 1'b1, 1'b0);
    sweep(8'h7F, 8'h00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
